// File: rtl/conv_sequencer.sv
// Address/control sequencer for 1-D linear convolution Z[i] = sum_j X[i-j]*Y[j].
// Walks (i, j), skips out-of-range terms, accumulates products and writes each Z word.
module conv_sequencer #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH_Y = 5,
   parameter int ADDR_WIDTH_X = 5,
   parameter int ADDR_WIDTH_Z = 6,
   parameter int ACC_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [ADDR_WIDTH_X-1:0] size_X,
   input  logic [ADDR_WIDTH_Y-1:0] size_Y,
   output logic [ADDR_WIDTH_X-1:0] rom_addr_X,
   input  logic [DATA_WIDTH-1:0]   rom_data_X,
   output logic [ADDR_WIDTH_Y-1:0] mem_addr_Y,
   input  logic [DATA_WIDTH-1:0]   mem_data_Y,
   output logic [ADDR_WIDTH_Z-1:0] mem_addr_Z,
   output logic [ACC_WIDTH-1:0]    mem_data_Z,
   output logic                    write_Z,
   output logic                    busy,
   output logic                    done
);

   localparam int JW  = ADDR_WIDTH_Y + 1;
   localparam int LZW = ADDR_WIDTH_Z + 1;
   localparam int PW  = 2 * DATA_WIDTH;
   localparam int CW0 = (ADDR_WIDTH_Z > JW) ? ADDR_WIDTH_Z : JW;
   localparam int CW  = (CW0 > ADDR_WIDTH_X) ? CW0 : ADDR_WIDTH_X;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_MAC   = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]              state;
   logic [ADDR_WIDTH_Z-1:0] i;
   logic [JW-1:0]           j;
   logic [ACC_WIDTH-1:0]    acc;
   logic [ADDR_WIDTH_X-1:0] sz_x;
   logic [ADDR_WIDTH_Y-1:0] sz_y;

   logic [LZW-1:0]       len_z;
   logic [CW-1:0]        i_ext, j_ext, diff;
   logic                 term_valid, last_y, last_i;
   logic [PW-1:0]        prod;
   logic [ACC_WIDTH-1:0] acc_sum;

   // All index arithmetic is done at a common width so i-j and the range checks never truncate.
   always_comb begin
      len_z      = LZW'(sz_x) + LZW'(sz_y) - LZW'(1);
      i_ext      = CW'(i);
      j_ext      = CW'(j);
      diff       = i_ext - j_ext;
      term_valid = (j_ext <= i_ext) && (diff < CW'(sz_x));
      last_y     = (j == JW'(sz_y));
      last_i     = ((LZW'(i) + LZW'(1)) == len_z);
      prod       = PW'(rom_data_X) * PW'(mem_data_Y);
      acc_sum    = acc + ACC_WIDTH'(prod);
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state      <= S_IDLE;
         i          <= '0;
         j          <= '0;
         acc        <= '0;
         sz_x       <= '0;
         sz_y       <= '0;
         rom_addr_X <= '0;
         mem_addr_Y <= '0;
         mem_addr_Z <= '0;
         mem_data_Z <= '0;
         write_Z    <= 1'b0;
      end else begin
         write_Z <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sz_x <= size_X;
                  sz_y <= size_Y;
                  if (size_X == '0 || size_Y == '0) begin
                     state <= S_DONE;
                  end else begin
                     i     <= '0;
                     j     <= '0;
                     acc   <= '0;
                     state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               // Z outputs are registered here so they are valid together during WRITE.
               if (last_y) begin
                  write_Z    <= 1'b1;
                  mem_addr_Z <= i;
                  mem_data_Z <= acc;
                  state      <= S_WRITE;
               end else if (term_valid) begin
                  mem_addr_Y <= ADDR_WIDTH_Y'(j);
                  rom_addr_X <= ADDR_WIDTH_X'(diff);
                  state      <= S_READ;
               end else begin
                  j <= j + JW'(1);
               end
            end
            S_READ: state <= S_MAC;
            S_MAC: begin
               acc   <= acc_sum;
               j     <= j + JW'(1);
               state <= S_CHECK;
            end
            S_WRITE: begin
               acc <= '0;
               j   <= '0;
               if (last_i) begin
                  state <= S_DONE;
               end else begin
                  i     <= i + ADDR_WIDTH_Z'(1);
                  state <= S_CHECK;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == S_CHECK) || (state == S_READ) || (state == S_MAC) || (state == S_WRITE);
      done = (state == S_DONE);
   end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Control/address sequencer for the 1-D linear convolution datapath: Z[i] = sum over j of X[i-j]*Y[j], for 0 <= i-j < size_X.
- Walks output index i and kernel index j, and skips out-of-range terms.
- Drives read addresses to the Y memory and the X ROM, then multiply-accumulates their data.
- Writes each finished Z word to the Z memory with a one-cycle strobe.
- Sits between the top-level start/done handshake and the three memories; replaces per-datapath ad-hoc control.

Parameters:
- DATA_WIDTH, 8: width of X and Y samples (unsigned).
- ADDR_WIDTH_Y, 5: Y memory address and size width.
- ADDR_WIDTH_X, 5: X ROM address and size width.
- ADDR_WIDTH_Z, 6: Z memory address width; must hold size_X+size_Y-2.
- ACC_WIDTH, 16: accumulator and Z data width.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a convolution; sampled only in IDLE
- size_X  in  ADDR_WIDTH_X  number of X samples; latched at start
- size_Y  in  ADDR_WIDTH_Y  number of Y samples; latched at start
- rom_addr_X  out  ADDR_WIDTH_X  X ROM read address (registered)
- rom_data_X  in  DATA_WIDTH  X ROM read data; synchronous, 1-cycle latency
- mem_addr_Y  out  ADDR_WIDTH_Y  Y memory read address (registered)
- mem_data_Y  in  DATA_WIDTH  Y memory read data; synchronous, 1-cycle latency
- mem_addr_Z  out  ADDR_WIDTH_Z  Z write address (registered)
- mem_data_Z  out  ACC_WIDTH  Z write data (registered)
- write_Z  out  1  Z write strobe, one cycle per word
- busy  out  1  high while a convolution is in progress
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: state=IDLE; all outputs 0; i, j, acc and latched sizes cleared. Asserting reset mid-run aborts immediately: no further write_Z and no done pulse.
- Registers:
  - i: ADDR_WIDTH_Z bits.
  - j: ADDR_WIDTH_Y+1 bits.
  - acc: ACC_WIDTH bits.
  - Latched sz_X and sz_Y.
  - len_Z = sz_X+sz_Y-1, computed at ADDR_WIDTH_Z+1 bits.
- IDLE: busy=0. On start=1:
  - Latch both sizes.
  - If either size is 0: go to DONE (no writes).
  - Otherwise clear i, j and acc, and go to CHECK.
- CHECK (1 cycle), evaluated in priority order:
  - If j == sz_Y: go to WRITE.
  - Else if j <= i and (i-j) < sz_X (term valid): register mem_addr_Y=j and rom_addr_X=i-j, then go to READ.
  - Else: j++ and stay in CHECK.
- READ (1 cycle): addresses are stable; memories sample them at the end of this cycle. Go to MAC.
- MAC (1 cycle): acc <= acc + rom_data_X*mem_data_Y.
  - Product is unsigned, 2*DATA_WIDTH bits.
  - Sum truncates to ACC_WIDTH (mod 2^16 wrap, no saturation).
  - j++, then go to CHECK.
- WRITE (1 cycle): write_Z=1, mem_addr_Z=i, mem_data_Z=acc, all valid together in this cycle.
  - On exit: acc=0, j=0.
  - If i+1 == len_Z: go to DONE.
  - Else: i++ and go to CHECK.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- busy=1 in CHECK, READ, MAC and WRITE only.
- start while busy or in DONE is ignored: no restart, no re-latch.
- Size inputs may change freely after start; only the latched values are used.
- write_Z is 0 outside WRITE. mem_addr_Z and mem_data_Z hold their last values between writes.
- Timing per output word: (number of j checks, including the final j==sz_Y check) + 2 cycles per valid term + 1 WRITE cycle.
- Max case: sz_X=sz_Y=31 gives len_Z=61, which fits ADDR_WIDTH_Z=6.

Test Plan:
- X={1,2,3}, size_X=3; Y={1,1}, size_Y=2; one start pulse.
  - Expect write_Z pulses at addresses 0,1,2,3 with data 1,3,5,3.
  - busy high for exactly 28 cycles, then done for 1 cycle, then IDLE.
- size_X=0 or size_Y=0 -> no write_Z; done pulses on the cycle after start; busy never rises.
- X={255,255}, Y={255,255} -> Z = 65025, 64514 (130050 mod 65536), 65025.
- size_X=1, X={7}; Y={1,2,3,4}, size_Y=4 -> Z = 7,14,21,28 at addresses 0..3; check rom_addr_X stays 0 on every read.
- Start re-pulsed mid-run, with sizes changed while busy -> ignored; results and cycle count identical to the undisturbed run.
- Reset asserted after the second write_Z -> all outputs 0 immediately; no further writes or done. A fresh start then reproduces the full first-scenario result.
